// File: rtl/pll_seq_pkg.sv
// Shared types, defaults and width helpers for the PLL lock sequencer.
// BYPASS exists only when PLL_BYPASS_FALLBACK_EN is defined.
package pll_seq_pkg;

  localparam int DEF_RESET_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT = 4096;
  localparam int DEF_LOCK_STABLE  = 256;
  localparam int DEF_LOSS_FILTER  = 4;
  localparam int DEF_MAX_RETRIES  = 3;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4,
    FAULT     = 3'd5
`ifdef PLL_BYPASS_FALLBACK_EN
    ,
    BYPASS    = 3'd6
`endif
  } state_t;

  // Width able to count 0..max-1 of the largest phase length.
  function automatic int cnt_w(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic int rc_w(input int r);
    return (r < 1) ? 1 : $clog2(r + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for the asynchronous PLL LOCK output.
// Ports: clk, rst_n (async active-low), d (raw), q (synchronised, reset 0).
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Power-up / relock sequencer for SB_PLL40_CORE in the REFERENCECLK domain.
// Ports: REFERENCECLK, RESET (async low), pll_lock, restart -> pll_resetb,
// pll_bypass, pll_ready, fault, lock_lost, retry_count.
// Macro PLL_BYPASS_FALLBACK_EN: exhausted retries fall back to BYPASS.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int LOSS_FILTER  = DEF_LOSS_FILTER,
  parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
  input  logic                          REFERENCECLK,
  input  logic                          RESET,
  input  logic                          pll_lock,
  input  logic                          restart,
  output logic                          pll_resetb,
  output logic                          pll_bypass,
  output logic                          pll_ready,
  output logic                          fault,
  output logic                          lock_lost,
  output logic [rc_w(MAX_RETRIES)-1:0] retry_count
);

  localparam int RCW = rc_w(MAX_RETRIES);
  localparam int CW  = cnt_w(RESET_CYCLES, LOCK_TIMEOUT,
                             LOCK_STABLE, LOSS_FILTER);

  localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] LF_LAST   = CW'(LOSS_FILTER - 1);
  localparam logic [RCW-1:0] RC_MAX   = RCW'(MAX_RETRIES);

  state_t        st;
  logic [CW-1:0] cnt;
  logic          lock_s;

  pll_lock_sync u_sync (
    .clk   (REFERENCECLK),
    .rst_n (RESET),
    .d     (pll_lock),
    .q     (lock_s)
  );

`ifndef PLL_BYPASS_FALLBACK_EN
  assign pll_bypass = 1'b0;
`endif

  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      st          <= HOLD;
      cnt         <= '0;
      pll_resetb  <= 1'b0;
      pll_ready   <= 1'b0;
      fault       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
`ifdef PLL_BYPASS_FALLBACK_EN
      pll_bypass  <= 1'b0;
`endif
    end else begin
      lock_lost <= 1'b0;
      if (restart) begin
        st          <= HOLD;
        cnt         <= '0;
        pll_resetb  <= 1'b0;
        pll_ready   <= 1'b0;
        fault       <= 1'b0;
        retry_count <= '0;
`ifdef PLL_BYPASS_FALLBACK_EN
        pll_bypass  <= 1'b0;
`endif
      end else begin
        unique case (st)
          HOLD: begin
            if (cnt == HOLD_LAST) begin
              st         <= WAIT_LOCK;
              cnt        <= '0;
              pll_resetb <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_LOCK: begin
            // lock is checked first so it wins on the timeout cycle
            if (lock_s) begin
              st  <= SETTLE;
              cnt <= '0;
            end else if (cnt == TO_LAST) begin
              st         <= FAIL;
              cnt        <= '0;
              pll_resetb <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SETTLE: begin
            if (!lock_s) begin
              st         <= FAIL;
              cnt        <= '0;
              pll_resetb <= 1'b0;
            end else if (cnt == STB_LAST) begin
              st        <= RUN;
              cnt       <= '0;
              pll_ready <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RUN: begin
            if (lock_s) begin
              cnt <= '0;
            end else if (cnt == LF_LAST) begin
              // loss of lock is a fresh start, not a failed attempt
              st          <= HOLD;
              cnt         <= '0;
              pll_ready   <= 1'b0;
              pll_resetb  <= 1'b0;
              lock_lost   <= 1'b1;
              retry_count <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          FAIL: begin
            cnt <= '0;
            if (retry_count == RC_MAX) begin
              fault <= 1'b1;
`ifdef PLL_BYPASS_FALLBACK_EN
              st         <= BYPASS;
              pll_bypass <= 1'b1;
              pll_ready  <= 1'b1;
`else
              st <= FAULT;
`endif
            end else begin
              st          <= HOLD;
              retry_count <= retry_count + 1'b1;
            end
          end
          FAULT: begin
          end
`ifdef PLL_BYPASS_FALLBACK_EN
          BYPASS: begin
          end
`endif
          default: begin
            st  <= HOLD;
            cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer (small parameter set).
// Directed scenarios plus randomised lock/restart traffic vs a model.
module tb_pll_lock_sequencer;

  localparam int RESET_CYCLES = 4;
  localparam int LOCK_TIMEOUT = 32;
  localparam int LOCK_STABLE  = 8;
  localparam int LOSS_FILTER  = 3;
  localparam int MAX_RETRIES  = 2;
  localparam int RCW          = $clog2(MAX_RETRIES + 1);

  localparam int M_HOLD   = 0;
  localparam int M_WAIT   = 1;
  localparam int M_SETTLE = 2;
  localparam int M_RUN    = 3;
  localparam int M_FAIL   = 4;
  localparam int M_FAULT  = 5;
  localparam int M_BYP    = 6;

  logic           REFERENCECLK = 1'b0;
  logic           RESET = 1'b1;
  logic           pll_lock = 1'b0;
  logic           restart = 1'b0;
  logic           pll_resetb;
  logic           pll_bypass;
  logic           pll_ready;
  logic           fault;
  logic           lock_lost;
  logic [RCW-1:0] retry_count;

  int nvec = 0;
  int nerr = 0;

  // model state
  int   ph, since, cyc, lowrun, tries;
  logic h1, h2, e_lost;

  pll_lock_sequencer #(
    .RESET_CYCLES (RESET_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .LOCK_STABLE  (LOCK_STABLE),
    .LOSS_FILTER  (LOSS_FILTER),
    .MAX_RETRIES  (MAX_RETRIES)
  ) dut (
    .REFERENCECLK (REFERENCECLK),
    .RESET        (RESET),
    .pll_lock     (pll_lock),
    .restart      (restart),
    .pll_resetb   (pll_resetb),
    .pll_bypass   (pll_bypass),
    .pll_ready    (pll_ready),
    .fault        (fault),
    .lock_lost    (lock_lost),
    .retry_count  (retry_count)
  );

  always #5 REFERENCECLK = ~REFERENCECLK;

  function automatic void go(input int p);
    ph     = p;
    since  = cyc;
    lowrun = 0;
  endfunction

  function automatic void model_reset();
    ph     = M_HOLD;
    since  = 0;
    cyc    = 0;
    lowrun = 0;
    tries  = 0;
    h1     = 1'b0;
    h2     = 1'b0;
    e_lost = 1'b0;
  endfunction

  // one rising edge; LOCK is seen two edges after it is sampled
  function automatic void model_step(input logic pl, input logic rs);
    logic ls;
    int   spent;
    cyc++;
    ls     = h2;
    h2     = h1;
    h1     = pl;
    e_lost = 1'b0;
    spent  = cyc - since;
    if (rs) begin
      tries = 0;
      go(M_HOLD);
    end else begin
      case (ph)
        M_HOLD:
          if (spent == RESET_CYCLES) go(M_WAIT);
        M_WAIT:
          if (ls) go(M_SETTLE);
          else if (spent == LOCK_TIMEOUT) go(M_FAIL);
        M_SETTLE:
          if (!ls) go(M_FAIL);
          else if (spent == LOCK_STABLE) go(M_RUN);
        M_RUN: begin
          lowrun = ls ? 0 : lowrun + 1;
          if (lowrun == LOSS_FILTER) begin
            e_lost = 1'b1;
            tries  = 0;
            go(M_HOLD);
          end
        end
        M_FAIL:
          if (tries == MAX_RETRIES) begin
`ifdef PLL_BYPASS_FALLBACK_EN
            go(M_BYP);
`else
            go(M_FAULT);
`endif
          end else begin
            tries++;
            go(M_HOLD);
          end
        default: ;
      endcase
    end
  endfunction

  // outputs follow from the phase, plus the loss pulse
  function automatic logic [4+RCW:0] model_out();
    logic rb, by, rd, ft;
    rb = (ph == M_WAIT) || (ph == M_SETTLE) || (ph == M_RUN);
    by = (ph == M_BYP);
    rd = (ph == M_RUN) || (ph == M_BYP);
    ft = (ph == M_FAULT) || (ph == M_BYP);
    return {rb, by, rd, ft, e_lost, RCW'(tries)};
  endfunction

  task automatic check_vec(input string tag);
    logic [4+RCW:0] obs, exp;
    obs = {pll_resetb, pll_bypass, pll_ready, fault, lock_lost,
           retry_count};
    exp = model_out();
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic pl, input logic rs,
                      input string tag);
    @(negedge REFERENCECLK);
    pll_lock = pl;
    restart  = rs;
    @(posedge REFERENCECLK);
    model_step(pl, rs);
    #1;
    check_vec(tag);
  endtask

  initial begin
    int   rb_at, rdy_at, nl;
    logic lvl;
    int   run;
    logic rs;

    // reset state
    #2 RESET = 1'b0;
    #1;
    model_reset();
    check_vec("reset");
    repeat (3) @(posedge REFERENCECLK);
    #2 RESET = 1'b1;

    // first lock: LOCK raised for edge 11
    rb_at  = -1;
    rdy_at = -1;
    for (int i = 1; i <= 30; i++) begin
      step(i > 10, 1'b0, "lockup");
      if (pll_resetb && rb_at < 0) rb_at = i;
      if (pll_ready && rdy_at < 0) rdy_at = i;
    end
    chk("resetb_rise_cycle", rb_at, 4);
    chk("ready_latency", rdy_at - 11, 10);
    chk("retry_after_lock", int'(retry_count), 0);

    // short glitch ignored, long one is a loss
    nl = 0;
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, "glitch2");
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, "glitch2_hi");
      nl += int'(lock_lost);
    end
    chk("ready_after_glitch", int'(pll_ready), 1);
    chk("lost_after_glitch", nl, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, "loss3");
      nl += int'(lock_lost);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, "loss3_hi");
      nl += int'(lock_lost);
    end
    chk("lost_pulses", nl, 1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, "relock");
    chk("ready_relock", int'(pll_ready), 1);

    // no lock: three timeouts exhaust retries
    for (int i = 0; i < 150; i++) step(1'b0, 1'b0, "timeouts");
    chk("fault_set", int'(fault), 1);
    chk("resetb_fault", int'(pll_resetb), 0);
    chk("retry_max", int'(retry_count), MAX_RETRIES);

    // restart out of fault, then lock
    step(1'b1, 1'b1, "restart_fault");
    chk("fault_clear", int'(fault), 0);
    chk("retry_clear", int'(retry_count), 0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, "lock2");
    chk("ready_lock2", int'(pll_ready), 1);

    // one low cycle seen in SETTLE cycle 5
    step(1'b1, 1'b1, "restart_s");
    for (int i = 1; i <= 20; i++) step(i != 8, 1'b0, "settle_drop");
    chk("retry_settle_drop", int'(retry_count), 1);

    // restart while settling
    step(1'b1, 1'b1, "restart_s2");
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, "settle_run");
    step(1'b1, 1'b1, "restart_in_settle");
    chk("resetb_restart", int'(pll_resetb), 0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, "after_restart");

    // lock arriving exactly on the timeout cycle wins
    step(1'b0, 1'b1, "restart_to");
    for (int i = 1; i <= 50; i++) step(i >= 34, 1'b0, "to_edge");
    chk("to_edge_ready", int'(pll_ready), 1);
    chk("to_edge_retry", int'(retry_count), 0);

    // one cycle later is a failure
    step(1'b0, 1'b1, "restart_to2");
    for (int i = 1; i <= 40; i++) step(i >= 35, 1'b0, "to_late");
    chk("to_late_retry", int'(retry_count), 1);

    // randomised LOCK runs and sparse restarts
    lvl = 1'b1;
    run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        lvl = ~lvl;
        if (lvl)
          run = int'($urandom_range(1, 60));
        else if ($urandom_range(0, 9) == 0)
          run = 50;
        else
          run = int'($urandom_range(1, 5));
      end
      run--;
      rs = ($urandom_range(0, 249) == 0);
      if (i == 1500) begin
        #1 RESET = 1'b0;
        #1;
        model_reset();
        check_vec("async_reset");
        #1 RESET = 1'b1;
      end
      step(lvl, rs, "rand");
    end

`ifdef PLL_BYPASS_FALLBACK_EN
    step(1'b0, 1'b1, "byp_restart");
    for (int i = 0; i < 130; i++) step(1'b0, 1'b0, "byp_fail");
    chk("byp_bypass", int'(pll_bypass), 1);
    chk("byp_ready", int'(pll_ready), 1);
    chk("byp_fault", int'(fault), 1);
    step(1'b0, 1'b1, "byp_leave");
    chk("byp_bypass_off", int'(pll_bypass), 0);
    chk("byp_ready_off", int'(pll_ready), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
